voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/synth_pkg.sv | 47 ++++
 rtl/note_freq_rom.sv | 42 ++++
 rtl/voice_allocator.sv | 202 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
// Note-to-phase-increment table for 48 kHz output, A4 (note 69) = 440 Hz.
package synth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } alloc_state_t;

  localparam int NUM_VOICES_DEF = 8;
  localparam int FREQ_W_DEF     = 32;
  localparam int VOL_W_DEF      = 16;

  localparam int INC_W = 32;
  typedef logic [127:0][INC_W-1:0] inc_tab_t;

  // Increments for notes 120..131 (C9..B9), truncated. Lower octaves halve per octave.
  function automatic logic [INC_W-1:0] top_octave_inc(input int semi);
    case (semi)
      0:       return 32'd749115497;
      1:       return 32'd793660223;
      2:       return 32'd840853716;
      3:       return 32'd890853480;
      4:       return 32'd943826384;
      5:       return 32'd999949222;
      6:       return 32'd1059409297;
      7:       return 32'd1122405052;
      8:       return 32'd1189146730;
      9:       return 32'd1259857073;
      10:      return 32'd1334772073;
      default: return 32'd1414141752;
    endcase
  endfunction

  function automatic inc_tab_t build_inc_tab();
    inc_tab_t t;
    t = '0;
    for (int n = 0; n < 128; n++) begin
      t[n] = top_octave_inc(n % 12) >> (10 - n / 12);
    end
    return t;
  endfunction

  localparam inc_tab_t NOTE_INC = build_inc_tab();

endpackage

// File: rtl/note_freq_rom.sv
// Registered note-number to phase-increment lookup; one cycle latency.
// No handshake: output follows the note input every cycle.
module note_freq_rom
  import synth_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        i_note,
  output logic [FREQ_W-1:0] o_freq
);

  localparam logic [INC_W-1:0] INC0 = NOTE_INC[0];

  logic [INC_W-1:0]  w_inc;
  logic [FREQ_W-1:0] w_freq;
  logic [FREQ_W-1:0] w_freq0;
  logic [FREQ_W-1:0] r_freq;

  assign w_inc = NOTE_INC[i_note];

  // Narrow outputs keep the most significant increment bits so pitch stays correct.
  if (FREQ_W >= INC_W) begin : g_wide
    assign w_freq  = FREQ_W'(w_inc);
    assign w_freq0 = FREQ_W'(INC0);
  end else begin : g_narrow
    assign w_freq  = w_inc[INC_W-1 -: FREQ_W];
    assign w_freq0 = INC0[INC_W-1 -: FREQ_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_freq <= w_freq0;
    end else begin
      r_freq <= w_freq;
    end
  end

  assign o_freq = r_freq;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator with per-voice AR envelope; event committed NUM_VOICES+2 cycles after transfer.
// note_ready is low from the cycle after a transfer until the allocation has been applied.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = NUM_VOICES_DEF,
  parameter int FREQ_W       = FREQ_W_DEF,
  parameter int VOL_W        = VOL_W_DEF,
  parameter int ATTACK_STEP  = 2048,
  parameter int RELEASE_STEP = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         note_valid,
  output logic                         note_ready,
  input  logic                         note_on,
  input  logic [6:0]                   note_code,
  input  logic                         env_tick,
  output logic [NUM_VOICES*FREQ_W-1:0] frequencies,
  output logic [NUM_VOICES*VOL_W-1:0]  voice_volumes,
  output logic [NUM_VOICES-1:0]        voice_active
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(NUM_VOICES + 1);
  localparam logic [VOL_W:0] VOL_MAX = {1'b0, {VOL_W{1'b1}}};
  localparam logic [VOL_W:0] ATK     = (VOL_W+1)'(ATTACK_STEP);
  localparam logic [VOL_W:0] REL     = (VOL_W+1)'(RELEASE_STEP);

  alloc_state_t r_state, w_state_nxt;

  logic [NUM_VOICES-1:0] r_gate;
  logic [6:0]            r_note [NUM_VOICES];
  logic [VOL_W-1:0]      r_vol  [NUM_VOICES];
  logic [VOL_W-1:0]      w_vol_nxt [NUM_VOICES];
  logic [IW-1:0]         r_steal_ptr;

  logic [CW-1:0]    r_scan_cnt;
  logic [IW-1:0]    w_rd_idx;
  logic             r_ev_on;
  logic [6:0]       r_ev_code;

  logic             r_p_vld;
  logic             r_p_gate;
  logic [6:0]       r_p_note;
  logic [VOL_W-1:0] r_p_vol;
  logic [IW-1:0]    r_p_idx;
  logic             w_p_match;

  logic             r_match_fnd, r_idle_fnd, r_rel_fnd;
  logic [IW-1:0]    r_match_idx, r_idle_idx, r_rel_idx;
  logic [VOL_W-1:0] r_rel_vol;

  logic             w_xfer;
  logic             w_wr;
  logic             w_clr;
  logic             w_steal;
  logic [IW-1:0]    w_tgt;

  assign note_ready = (r_state == ST_IDLE) && !reset;
  assign w_xfer     = note_valid && note_ready;
  assign w_rd_idx   = IW'(r_scan_cnt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer) w_state_nxt = ST_SCAN;
      ST_SCAN:   if (r_scan_cnt == CW'(NUM_VOICES)) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Note-on also matches a decaying voice; note-off only a held one.
  assign w_p_match = (r_p_note == r_ev_code) && (r_p_gate || (r_ev_on && (r_p_vol != '0)));

  // Voice reads are registered, so the last index is judged one cycle after it is read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_scan_cnt  <= '0;
      r_ev_on     <= 1'b0;
      r_ev_code   <= '0;
      r_p_vld     <= 1'b0;
      r_p_gate    <= 1'b0;
      r_p_note    <= '0;
      r_p_vol     <= '0;
      r_p_idx     <= '0;
      r_match_fnd <= 1'b0;
      r_idle_fnd  <= 1'b0;
      r_rel_fnd   <= 1'b0;
      r_match_idx <= '0;
      r_idle_idx  <= '0;
      r_rel_idx   <= '0;
      r_rel_vol   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p_vld <= 1'b0;
      if (w_xfer) begin
        r_ev_on     <= note_on;
        r_ev_code   <= note_code;
        r_scan_cnt  <= '0;
        r_match_fnd <= 1'b0;
        r_idle_fnd  <= 1'b0;
        r_rel_fnd   <= 1'b0;
      end
      if (r_state == ST_SCAN) begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
        r_p_vld    <= (r_scan_cnt < CW'(NUM_VOICES));
        r_p_gate   <= r_gate[w_rd_idx];
        r_p_note   <= r_note[w_rd_idx];
        r_p_vol    <= r_vol[w_rd_idx];
        r_p_idx    <= w_rd_idx;
      end
      if (r_p_vld) begin
        if (!r_match_fnd && w_p_match) begin
          r_match_fnd <= 1'b1;
          r_match_idx <= r_p_idx;
        end
        if (!r_idle_fnd && !r_p_gate && (r_p_vol == '0)) begin
          r_idle_fnd <= 1'b1;
          r_idle_idx <= r_p_idx;
        end
        if (!r_p_gate && (!r_rel_fnd || (r_p_vol < r_rel_vol))) begin
          r_rel_fnd <= 1'b1;
          r_rel_idx <= r_p_idx;
          r_rel_vol <= r_p_vol;
        end
      end
    end
  end

  always_comb begin
    w_tgt   = r_steal_ptr;
    w_wr    = 1'b0;
    w_clr   = 1'b0;
    w_steal = 1'b0;
    if (r_state == ST_COMMIT) begin
      if (r_ev_on) begin
        w_wr = 1'b1;
        if (r_match_fnd) begin
          w_tgt = r_match_idx;
        end else if (r_idle_fnd) begin
          w_tgt = r_idle_idx;
          w_clr = 1'b1;
        end else if (r_rel_fnd) begin
          w_tgt = r_rel_idx;
          w_clr = 1'b1;
        end else begin
          w_clr   = 1'b1;
          w_steal = 1'b1;
        end
      end else if (r_match_fnd) begin
        w_wr  = 1'b1;
        w_tgt = r_match_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gate      <= '0;
      r_steal_ptr <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_vol[i]  <= '0;
      end
    end else begin
      if (w_steal) begin
        r_steal_ptr <= (r_steal_ptr == IW'(NUM_VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (w_wr && (w_tgt == IW'(i))) begin
          r_gate[i] <= r_ev_on;
          if (r_ev_on) r_note[i] <= r_ev_code;
          if (w_clr)   r_vol[i]  <= '0;
        end else if (env_tick) begin
          r_vol[i] <= w_vol_nxt[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    logic [VOL_W:0] w_up;
    assign w_up = {1'b0, r_vol[g]} + ATK;
    assign w_vol_nxt[g] = r_gate[g]
        ? ((w_up > VOL_MAX) ? VOL_MAX[VOL_W-1:0] : w_up[VOL_W-1:0])
        : (({1'b0, r_vol[g]} > REL) ? (r_vol[g] - REL[VOL_W-1:0]) : '0);

    assign voice_volumes[g*VOL_W +: VOL_W] = r_vol[g];
    assign voice_active[g] = r_gate[g] || (r_vol[g] != '0);

    note_freq_rom #(.FREQ_W(FREQ_W)) u_rom (
      .clk    (clk),
      .reset  (reset),
      .i_note (r_note[g]),
      .o_freq (frequencies[g*FREQ_W +: FREQ_W])
    );
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: an 8-voice default instance and a 2-voice
// instance with ATTACK_STEP=300 for the small-volume release case.
module tb_voice_allocator;

  localparam int NV = 8;
  localparam int VW = 16;
  localparam int FW = 32;

  logic clk;
  logic reset;
  logic note_valid, note_ready, note_on, env_tick;
  logic [6:0] note_code;
  logic [NV*FW-1:0] frequencies;
  logic [NV*VW-1:0] voice_volumes;
  logic [NV-1:0]    voice_active;

  logic b_valid, b_ready, b_on, b_tick;
  logic [6:0]  b_code;
  logic [2*FW-1:0] b_freqs;
  logic [2*VW-1:0] b_vols;
  logic [1:0]      b_active;

  int checks = 0;
  int failures = 0;

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready),
    .note_on(note_on), .note_code(note_code), .env_tick(env_tick),
    .frequencies(frequencies), .voice_volumes(voice_volumes), .voice_active(voice_active)
  );

  voice_allocator #(.NUM_VOICES(2), .ATTACK_STEP(300)) dut_b (
    .clk(clk), .reset(reset), .note_valid(b_valid), .note_ready(b_ready),
    .note_on(b_on), .note_code(b_code), .env_tick(b_tick),
    .frequencies(b_freqs), .voice_volumes(b_vols), .voice_active(b_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] vol(input int i);
    return voice_volumes[i*VW +: VW];
  endfunction

  task automatic send(input bit b, input bit on, input logic [6:0] code, output int low);
    int waitc;
    waitc = 0;
    low = 0;
    @(negedge clk);
    while (!(b ? b_ready : note_ready) && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    if (waitc >= 50) check("ready_wait", b ? b_ready : note_ready, 1);
    if (b) begin
      b_valid = 1'b1; b_on = on; b_code = code;
    end else begin
      note_valid = 1'b1; note_on = on; note_code = code;
    end
    @(negedge clk);
    note_valid = 1'b0;
    b_valid = 1'b0;
    while (!(b ? b_ready : note_ready) && low < 50) begin
      low++;
      @(negedge clk);
    end
    if (low >= 50) check("commit_wait", b ? b_ready : note_ready, 1);
  endtask

  task automatic tick(input bit b, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (b) b_tick = 1'b1; else env_tick = 1'b1;
      @(negedge clk);
      env_tick = 1'b0;
      b_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int low;
    reset = 1'b1;
    note_valid = 1'b0; note_on = 1'b0; note_code = '0; env_tick = 1'b0;
    b_valid = 1'b0; b_on = 1'b0; b_code = '0; b_tick = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", note_ready, 0);
    check("rst_active", voice_active, 0);
    check("rst_vol_any", |voice_volumes, 0);
    check("rst_freq0", frequencies[FW-1:0], 731558);
    check("rst_b_ready", b_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", note_ready, 1);

    // First note-on lands in voice 0; ten busy cycles for eight voices.
    send(0, 1, 7'd60, low);
    check("on60_busy", low, 10);
    check("on60_gate", dut.r_gate, 8'h01);
    check("on60_note", dut.r_note[0], 60);
    check("on60_vol", vol(0), 0);
    @(negedge clk);
    check("on60_freq", frequencies[FW-1:0], 23409859);
    tick(0, 5);
    check("attack5", vol(0), 10240);
    check("attack5_active", voice_active, 8'h01);

    // Retrigger keeps volume, no second voice used.
    send(0, 1, 7'd60, low);
    check("retrig_gate", dut.r_gate, 8'h01);
    check("retrig_vol", vol(0), 10240);

    tick(0, 27);
    check("sat_reach", vol(0), 65535);
    tick(0, 10);
    check("sat_hold", vol(0), 65535);

    // Two-voice instance: release from 300 falls to 0 without wrapping.
    send(1, 1, 7'd10, low);
    check("b_busy", low, 4);
    tick(1, 1);
    check("b_vol300", b_vols[VW-1:0], 300);
    send(1, 0, 7'd10, low);
    check("b_off_active", b_active, 2'b01);
    tick(1, 1);
    check("b_rel_vol", b_vols[VW-1:0], 0);
    check("b_rel_active", b_active, 2'b00);

    // Fill all voices, then steal in round-robin order.
    do_reset();
    for (int n = 60; n < 68; n++) send(0, 1, 7'(n), low);
    check("fill_gate", dut.r_gate, 8'hFF);
    check("fill_note7", dut.r_note[7], 67);
    tick(0, 2);
    send(0, 1, 7'd72, low);
    check("steal0_note", dut.r_note[0], 72);
    check("steal0_vol", vol(0), 0);
    check("steal0_vol1", vol(1), 4096);
    check("steal0_ptr", dut.r_steal_ptr, 1);
    send(0, 1, 7'd74, low);
    check("steal1_note", dut.r_note[1], 74);
    check("steal1_vol", vol(1), 0);
    check("steal1_ptr", dut.r_steal_ptr, 2);

    // Quietest released voice is reused.
    send(0, 0, 7'd62, low);
    tick(0, 1);
    send(0, 0, 7'd64, low);
    check("rel_vol2", vol(2), 3584);
    check("rel_vol4", vol(4), 6144);
    send(0, 1, 7'd70, low);
    check("relpick_note", dut.r_note[2], 70);
    check("relpick_vol", vol(2), 0);
    check("relpick_gate", dut.r_gate, 8'hEF);
    check("relpick_ptr", dut.r_steal_ptr, 2);

    send(0, 0, 7'd99, low);
    check("nomatch_gate", dut.r_gate, 8'hEF);
    check("nomatch_vol4", vol(4), 6144);
    check("nomatch_ptr", dut.r_steal_ptr, 2);

    // Reset during scan discards the pending note-on.
    do_reset();
    note_valid = 1'b1; note_on = 1'b1; note_code = 7'd60;
    @(negedge clk);
    note_valid = 1'b0;
    check("scan_busy", note_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", note_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", note_ready, 1);
    repeat (12) @(negedge clk);
    check("midrst_gate", dut.r_gate, 8'h00);
    check("midrst_active", voice_active, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
